// File: rtl/switch_allocator_if.sv
// Switch allocator port bundle: route-compute requests, buffer heads,
// output readiness in; grants, pops, crossbar selects out.
interface switch_allocator_if #(
   parameter int BUFFERS = 4
);
   localparam int SEL_W = $clog2(BUFFERS);

   logic [BUFFERS-1:0]            rc_valid;
   logic [BUFFERS-1:0][SEL_W-1:0] rc_out_sel;
   logic [BUFFERS-1:0]            flit_valid;
   logic [BUFFERS-1:0]            flit_last;
   logic [BUFFERS-1:0]            out_ready;
   logic [BUFFERS-1:0]            rc_grant;
   logic [BUFFERS-1:0]            in_pop;
   logic [BUFFERS-1:0]            out_valid;
   logic [BUFFERS-1:0][SEL_W-1:0] xbar_sel;
   logic                          err_bad_port;

   modport master (
      output rc_valid, rc_out_sel, flit_valid,
      output flit_last, out_ready,
      input  rc_grant, in_pop, out_valid,
      input  xbar_sel, err_bad_port
   );

   modport slave (
      input  rc_valid, rc_out_sel, flit_valid,
      input  flit_last, out_ready,
      output rc_grant, in_pop, out_valid,
      output xbar_sel, err_bad_port
   );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator: holds an output for a whole
// packet, forwards flits from the owner, releases on the tail pop.
module switch_allocator #(
   parameter int BUFFERS = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   switch_allocator_if.slave sa
);
   localparam int SEL_W = $clog2(BUFFERS);

   typedef enum logic {IDLE, ACTIVE} state_t;
   typedef logic [SEL_W-1:0] sel_t;

   state_t             state  [BUFFERS];
   sel_t               owner  [BUFFERS];
   sel_t               rr_ptr [BUFFERS];
   logic [BUFFERS-1:0] busy;
   logic               err_q;

   sel_t               win [BUFFERS];
   logic [BUFFERS-1:0] win_vld;
   logic [BUFFERS-1:0] grant;
   logic [BUFFERS-1:0] pop_o;
   logic [BUFFERS-1:0] tail_o;
   logic [BUFFERS-1:0] pop_i;
   logic [BUFFERS-1:0] ovalid;
   logic [BUFFERS-1:0] bad;

   // Idle outputs pick the first eligible input at or after rr_ptr
   always_comb begin
      int idx;
      idx     = 0;
      win_vld = '0;
      grant   = '0;
      for (int o = 0; o < BUFFERS; o++) begin
         win[o] = '0;
         if (state[o] == IDLE) begin
            for (int k = 0; k < BUFFERS; k++) begin
               idx = (int'(rr_ptr[o]) + k) % BUFFERS;
               if (!win_vld[o] && sa.rc_valid[idx] &&
                   !busy[idx] &&
                   sa.rc_out_sel[idx] == sel_t'(o)) begin
                  win_vld[o] = 1'b1;
                  win[o]     = sel_t'(idx);
                  grant[idx] = 1'b1;
               end
            end
         end
      end
   end

   // Active outputs stream the owner's head flit when the output is ready
   always_comb begin
      pop_o  = '0;
      tail_o = '0;
      pop_i  = '0;
      ovalid = '0;
      for (int o = 0; o < BUFFERS; o++) begin
         if (state[o] == ACTIVE) begin
            ovalid[o] = sa.flit_valid[owner[o]];
            pop_o[o]  = sa.flit_valid[owner[o]] &
                        sa.out_ready[o];
            tail_o[o] = pop_o[o] & sa.flit_last[owner[o]];
            if (pop_o[o])
               pop_i[owner[o]] = 1'b1;
         end
      end
   end

   // A request is bad when it names no existing output
   always_comb begin
      bad = '0;
      for (int i = 0; i < BUFFERS; i++) begin
         bad[i] = sa.rc_valid[i];
         for (int o = 0; o < BUFFERS; o++)
            if (sa.rc_out_sel[i] == sel_t'(o))
               bad[i] = 1'b0;
      end
   end

   // Crossbar select follows the owner register, so idle keeps the last one
   always_comb begin
      for (int o = 0; o < BUFFERS; o++)
         sa.xbar_sel[o] = owner[o];
   end

   assign sa.rc_grant     = grant  & {BUFFERS{n_rst}};
   assign sa.in_pop       = pop_i  & {BUFFERS{n_rst}};
   assign sa.out_valid    = ovalid & {BUFFERS{n_rst}};
   assign sa.err_bad_port = err_q;

   // Grant takes the output at the next edge; tail pop releases it
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int o = 0; o < BUFFERS; o++) begin
            state[o]  <= IDLE;
            owner[o]  <= '0;
            rr_ptr[o] <= '0;
         end
         busy  <= '0;
         err_q <= 1'b0;
      end else begin
         for (int o = 0; o < BUFFERS; o++) begin
            if (win_vld[o]) begin
               state[o]     <= ACTIVE;
               owner[o]     <= win[o];
               rr_ptr[o]    <= sel_t'((int'(win[o]) + 1) % BUFFERS);
               busy[win[o]] <= 1'b1;
            end else if (tail_o[o]) begin
               state[o]       <= IDLE;
               busy[owner[o]] <= 1'b0;
            end
         end
         if (|bad)
            err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: packet-level model checked every
// cycle, plus literal expectations for the named scenarios.
module tb_switch_allocator;
   localparam int B = 4;
   localparam int W = 2;

   logic clk = 1'b0;
   logic n_rst = 1'b0;

   switch_allocator_if #(.BUFFERS(4)) bus ();
   switch_allocator_if #(.BUFFERS(5)) bus5 ();

   switch_allocator #(.BUFFERS(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .sa    (bus)
   );

   switch_allocator #(.BUFFERS(5)) dut5 (
      .clk   (clk),
      .n_rst (n_rst),
      .sa    (bus5)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // packet model: owner per output (-1 = free), next-priority input
   int m_own [B];
   int m_ptr [B];
   int m_last [B];
   int n_own [B];
   int n_ptr [B];
   int n_last [B];

   logic [B-1:0]        exp_gnt = '0;
   logic [B-1:0]        exp_pop = '0;
   logic [B-1:0]        exp_ov = '0;
   logic [B-1:0][W-1:0] exp_xs = '0;

   int rem [B];
   int dut_pops [B];
   int gcyc [B];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   function automatic bit m_busy(int i);
      for (int o = 0; o < B; o++)
         if (m_own[o] == i) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      cyc++;
      for (int o = 0; o < B; o++) begin
         if (!n_rst) begin
            m_own[o]  = -1;
            m_ptr[o]  = 0;
            m_last[o] = 0;
         end else begin
            m_own[o]  = n_own[o];
            m_ptr[o]  = n_ptr[o];
            m_last[o] = n_last[o];
         end
      end
   end

   // Predict this cycle's outputs from the packet model and compare
   always @(negedge clk) begin : cmp
      int best, bd, d, w;
      exp_gnt = '0;
      exp_pop = '0;
      exp_ov  = '0;
      exp_xs  = '0;
      for (int o = 0; o < B; o++) begin
         n_own[o]  = -1;
         n_ptr[o]  = 0;
         n_last[o] = 0;
      end
      if (n_rst) begin
         for (int o = 0; o < B; o++) begin
            n_own[o]  = m_own[o];
            n_ptr[o]  = m_ptr[o];
            n_last[o] = m_last[o];
            if (m_own[o] < 0) begin
               exp_xs[o] = W'(m_last[o]);
               best = -1;
               bd   = B;
               for (int i = 0; i < B; i++) begin
                  if (bus.rc_valid[i] && !m_busy(i) &&
                      int'(bus.rc_out_sel[i]) == o) begin
                     d = (i - m_ptr[o] + B) % B;
                     if (d < bd) begin
                        bd   = d;
                        best = i;
                     end
                  end
               end
               if (best >= 0) begin
                  exp_gnt[best] = 1'b1;
                  n_own[o]  = best;
                  n_last[o] = best;
                  n_ptr[o]  = (best + 1) % B;
               end
            end else begin
               w = m_own[o];
               exp_xs[o] = W'(w);
               exp_ov[o] = bus.flit_valid[w];
               if (bus.flit_valid[w] && bus.out_ready[o]) begin
                  exp_pop[w] = 1'b1;
                  if (bus.flit_last[w]) n_own[o] = -1;
               end
            end
         end
      end
      for (int i = 0; i < B; i++) begin
         if (bus.in_pop[i]) dut_pops[i]++;
         if (bus.rc_grant[i]) gcyc[i] = cyc;
      end
      chk("rc_grant", 32'(bus.rc_grant), 32'(exp_gnt));
      chk("in_pop", 32'(bus.in_pop), 32'(exp_pop));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("xbar_sel", 32'(bus.xbar_sel), 32'(exp_xs));
      chk("err_bad_port", 32'(bus.err_bad_port), 32'd0);
   end

   task automatic drive();
      for (int i = 0; i < B; i++) begin
         bus.flit_valid[i] = rem[i] > 0;
         bus.flit_last[i]  = rem[i] == 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < B; i++) begin
         if (exp_pop[i] && rem[i] > 0) rem[i]--;
         if (exp_gnt[i]) bus.rc_valid[i] = 1'b0;
      end
      drive();
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      bus.rc_valid   = '0;
      bus.rc_out_sel = '0;
      bus.out_ready  = '1;
      for (int i = 0; i < B; i++) rem[i] = 0;
      drive();
      bus5.rc_valid   = '0;
      bus5.rc_out_sel = '0;
      bus5.flit_valid = '0;
      bus5.flit_last  = '0;
      bus5.out_ready  = '1;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      int base;
      for (int i = 0; i < B; i++) begin
         rem[i] = 0;
         dut_pops[i] = 0;
         gcyc[i] = 0;
         m_own[i] = -1;
         m_ptr[i] = 0;
         m_last[i] = 0;
      end
      do_reset();

      // single packet, input 1 -> output 2, 3 flits
      bus.rc_valid[1] = 1'b1;
      bus.rc_out_sel[1] = 2'd2;
      rem[1] = 3;
      drive();
      base = dut_pops[1];
      at_neg();
      chk("single_grant", 32'(bus.rc_grant), 32'h2);
      chk("single_no_fwd", 32'(bus.out_valid), 32'h0);
      tick();
      at_neg();
      chk("single_pop1", 32'(bus.in_pop), 32'h2);
      chk("single_ov1", 32'(bus.out_valid), 32'h4);
      chk("single_xsel", 32'(bus.xbar_sel[2]), 32'd1);
      tick();
      tick();
      at_neg();
      chk("single_pop3", 32'(bus.in_pop), 32'h2);
      tick();
      at_neg();
      chk("single_idle_ov", 32'(bus.out_valid), 32'h0);
      chk("single_idle_pop", 32'(bus.in_pop), 32'h0);
      chk("single_count", 32'(dut_pops[1] - base), 32'd3);
      tick();

      // contention: inputs 0,1,3 on output 2, 2 flits each
      do_reset();
      bus.rc_valid = 4'b1011;
      bus.rc_out_sel[0] = 2'd2;
      bus.rc_out_sel[1] = 2'd2;
      bus.rc_out_sel[3] = 2'd2;
      rem[0] = 2;
      rem[1] = 2;
      rem[3] = 2;
      drive();
      at_neg();
      chk("cont_first", 32'(bus.rc_grant), 32'h1);
      repeat (12) tick();
      chk("cont_gap01", 32'(gcyc[1] - gcyc[0]), 32'd3);
      chk("cont_gap13", 32'(gcyc[3] - gcyc[1]), 32'd3);
      chk("cont_drained", 32'(rem[0] + rem[1] + rem[3]), 32'd0);

      // backpressure: out_ready[2] low 2 cycles after first flit
      do_reset();
      bus.rc_valid[1] = 1'b1;
      bus.rc_out_sel[1] = 2'd2;
      rem[1] = 4;
      drive();
      base = dut_pops[1];
      tick();
      tick();
      bus.out_ready[2] = 1'b0;
      at_neg();
      chk("bp_stall1", 32'(bus.in_pop), 32'h0);
      chk("bp_ov_held", 32'(bus.out_valid), 32'h4);
      tick();
      at_neg();
      chk("bp_stall2", 32'(bus.in_pop), 32'h0);
      tick();
      bus.out_ready[2] = 1'b1;
      tick();
      tick();
      tick();
      at_neg();
      chk("bp_count", 32'(dut_pops[1] - base), 32'd4);
      chk("bp_released", 32'(bus.out_valid), 32'h0);
      tick();

      // parallel grants on outputs 3 and 1
      do_reset();
      bus.rc_valid = 4'b0101;
      bus.rc_out_sel[0] = 2'd3;
      bus.rc_out_sel[2] = 2'd1;
      rem[0] = 1;
      rem[2] = 1;
      drive();
      at_neg();
      chk("par_grant", 32'(bus.rc_grant), 32'h5);
      tick();
      at_neg();
      chk("par_xsel3", 32'(bus.xbar_sel[3]), 32'd0);
      chk("par_xsel1", 32'(bus.xbar_sel[1]), 32'd2);
      chk("par_ov", 32'(bus.out_valid), 32'ha);
      tick();
      tick();

      // reset mid-packet, then fresh request 3 -> 0
      do_reset();
      bus.rc_valid[1] = 1'b1;
      bus.rc_out_sel[1] = 2'd2;
      rem[1] = 4;
      drive();
      tick();
      tick();
      n_rst = 1'b0;
      bus.rc_valid[3] = 1'b1;
      bus.rc_out_sel[3] = 2'd0;
      #1;
      chk("rst_grant", 32'(bus.rc_grant), 32'h0);
      chk("rst_pop", 32'(bus.in_pop), 32'h0);
      chk("rst_ov", 32'(bus.out_valid), 32'h0);
      chk("rst_xsel", 32'(bus.xbar_sel), 32'h0);
      rem[1] = 0;
      drive();
      tick();
      tick();
      n_rst = 1'b1;
      rem[3] = 1;
      drive();
      at_neg();
      chk("rst_new_grant", 32'(bus.rc_grant), 32'h8);
      tick();
      at_neg();
      chk("rst_new_xsel", 32'(bus.xbar_sel[0]), 32'd3);
      chk("rst_new_ov", 32'(bus.out_valid), 32'h1);
      tick();

      // five-port instance: out-of-range select is flagged, never granted
      do_reset();
      bus5.rc_valid = 5'b10001;
      bus5.rc_out_sel[0] = 3'd7;
      bus5.rc_out_sel[4] = 3'd4;
      at_neg();
      chk("b5_grant", 32'(bus5.rc_grant), 32'h10);
      chk("b5_err_pre", 32'(bus5.err_bad_port), 32'd0);
      tick();
      bus5.rc_valid = '0;
      at_neg();
      chk("b5_err_set", 32'(bus5.err_bad_port), 32'd1);
      chk("b5_no_grant", 32'(bus5.rc_grant), 32'h0);
      tick();
      tick();
      tick();
      at_neg();
      chk("b5_err_sticky", 32'(bus5.err_bad_port), 32'd1);
      tick();
      n_rst = 1'b0;
      #1;
      chk("b5_err_rst", 32'(bus5.err_bad_port), 32'd0);
      tick();
      n_rst = 1'b1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter BUFFERS, default 4: number of switch ports; every port has one input buffer and one output port.
REQ-002 Derived SEL_W = $clog2(BUFFERS): port-select width, shared with the route compute out_sel field.
REQ-003 clk  input  1  single clock for the block.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 rc_valid  input  [BUFFERS]  input i holds a routed head flit that is awaiting allocation.
REQ-006 rc_out_sel  input  [BUFFERS][SEL_W]  requested output port for input i, from route compute.
REQ-007 flit_valid  input  [BUFFERS]  input buffer i has a flit at its head.
REQ-008 flit_last  input  [BUFFERS]  the head flit of input i is the packet tail.
REQ-009 out_ready  input  [BUFFERS]  output port o can accept a flit this cycle.
REQ-010 rc_grant  output  [BUFFERS]  single-cycle pulse: input i won its requested output.
REQ-011 in_pop  output  [BUFFERS]  input buffer i dequeues its head flit this cycle.
REQ-012 out_valid  output  [BUFFERS]  output o carries a valid flit this cycle.
REQ-013 xbar_sel  output  [BUFFERS][SEL_W]  input index driving crossbar output o.
REQ-014 err_bad_port  output  1  sticky flag: a request named an output index >= BUFFERS.

Function
REQ-015 Each output o SHALL hold registered state IDLE or ACTIVE, an owner register [SEL_W], and a round-robin pointer rr_ptr [SEL_W].
REQ-016 Each input SHALL hold a registered busy flag, set while the input owns an output.
REQ-017 An input's request is eligible for output o when rc_valid=1, rc_out_sel=o, and busy=0.
REQ-018 In IDLE, output o SHALL grant the first eligible input found by searching upward from rr_ptr, wrapping from BUFFERS-1 to 0.
REQ-019 The grant SHALL be combinational in decision cycle N: rc_grant[winner]=1 for exactly that cycle.
REQ-020 At edge N+1, output o SHALL go ACTIVE with owner=winner, input busy[winner] SHALL set, and rr_ptr SHALL become (winner+1) mod BUFFERS.
REQ-021 rr_ptr SHALL be unchanged in any cycle with no grant.
REQ-022 In ACTIVE, the datapath SHALL be: xbar_sel[o]=owner; out_valid[o]=flit_valid[owner]; in_pop[owner]=flit_valid[owner] & out_ready[o].
REQ-023 While ACTIVE, out_ready low SHALL stall the output: no pop, and state is held.
REQ-024 A pop with flit_last[owner]=1 SHALL return output o to IDLE and clear busy[owner] at the next edge.
REQ-025 There SHALL be no re-grant in the cycle of the tail pop: minimum one-cycle bubble between packets on the same output.
REQ-026 The first flit of a packet is forwarded no earlier than cycle N+1 after its grant.
REQ-027 Distinct outputs SHALL allocate independently and may grant in the same cycle; no input can win two outputs, since it requests only one.
REQ-028 A request with rc_out_sel >= BUFFERS SHALL never be granted, and SHALL set err_bad_port until reset.
REQ-029 In IDLE, out_valid[o]=0 and xbar_sel[o] holds its last owner.
REQ-030 in_pop[i]=0 for any input that is not busy.
REQ-031 rc_valid deasserting before a grant SHALL withdraw the request with no side effects.

Reset
REQ-032 n_rst low SHALL immediately force: all outputs IDLE; owner=0; rr_ptr=0; busy=0; rc_grant=0; in_pop=0; out_valid=0; xbar_sel=0; err_bad_port=0.
REQ-033 Reset asserted mid-packet SHALL abandon the allocation with no further pops; after release, fresh arbitration starts from rr_ptr=0.

Verification (BUFFERS=4)
REQ-034 Single packet: input 1 requests output 2 with 3 flits, out_ready=1 -> rc_grant[1] pulses in cycle N; in_pop[1] and out_valid[2] high in N+1..N+3; output 2 is IDLE at N+4.
REQ-035 Contention: inputs 0, 1 and 3 all request output 2 from reset -> grant order 0, 1, 3, with one bubble cycle between each tail and the next grant.
REQ-036 Backpressure: out_ready[2]=0 for 2 cycles mid-packet -> in_pop[1]=0 in those cycles; no flit is lost; the tail releases normally.
REQ-037 Parallel: input 0 requests output 3 and input 2 requests output 1 in the same cycle -> both rc_grant pulse together; xbar_sel[3]=0 and xbar_sel[1]=2.
REQ-038 Reset mid-packet: n_rst asserted after 1 of 4 flits -> all outputs are 0 immediately; after release, a new request from input 3 to output 0 is granted.
REQ-039 BUFFERS=5, rc_out_sel=7 -> no grant; err_bad_port=1 and stays 1 until reset.
